// File: rtl/i2c_bit_engine.sv
// I2C master bit engine: runs START / WRITE / READ / STOP as quarter-bit phases
// timed by the edges of the divider's slow clock, with clock-stretch support.
module i2c_bit_engine (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       phase_clk,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_byte,
    input  logic       ack_in,
    output logic [7:0] rx_byte,
    output logic       ack_out,
    output logic       done,
    output logic       err,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_drive_low,
    output logic       sda_drive_low
);

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        START_Q,
        BIT_Q,
        STOP_Q,
        REJECT,
        DONE
    } state_t;

    state_t     state;
    logic [2:0] phase_sync;
    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       tick;
    logic [1:0] cmd_l;
    logic [7:0] tx_reg;
    logic [7:0] rx_shift;
    logic       ack_l;
    logic       ack_tmp;
    logic       bus_held;
    logic       started;
    logic [1:0] quarter;
    logic [3:0] bit_cnt;
    logic [3:0] next_bit;
    logic       next_bit_low;

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            phase_sync <= 3'b000;
            scl_sync   <= 2'b11;
            sda_sync   <= 2'b11;
        end else begin
            phase_sync <= {phase_sync[1:0], phase_clk};
            scl_sync   <= {scl_sync[0], scl_i};
            sda_sync   <= {sda_sync[0], sda_i};
        end
    end

    assign tick = phase_sync[1] ^ phase_sync[2];
    assign busy = ~cmd_ready;

    // SDA level for the bit about to start; bit 8 is the ACK slot
    always_comb begin
        next_bit     = started ? (bit_cnt + 4'd1) : 4'd0;
        next_bit_low = 1'b0;
        if (next_bit == 4'd8) begin
            next_bit_low = (cmd_l == CMD_READ) ? ~ack_l : 1'b0;
        end else if (cmd_l != CMD_READ) begin
            next_bit_low = ~tx_reg[3'd7 - next_bit[2:0]];
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            rx_byte       <= 8'h00;
            ack_out       <= 1'b1;
            scl_drive_low <= 1'b0;
            sda_drive_low <= 1'b0;
            cmd_l         <= CMD_START;
            tx_reg        <= 8'h00;
            rx_shift      <= 8'h00;
            ack_l         <= 1'b1;
            ack_tmp       <= 1'b1;
            bus_held      <= 1'b0;
            started       <= 1'b0;
            quarter       <= 2'd0;
            bit_cnt       <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_l     <= cmd;
                        tx_reg    <= tx_byte;
                        ack_l     <= ack_in;
                        cmd_ready <= 1'b0;
                        started   <= 1'b0;
                        quarter   <= 2'd0;
                        bit_cnt   <= 4'd0;
                        if (cmd != CMD_START && !bus_held) begin
                            state <= REJECT;
                        end else begin
                            case (cmd)
                                CMD_START: begin
                                    state    <= START_Q;
                                    bus_held <= 1'b1;
                                end
                                CMD_STOP: begin
                                    state    <= STOP_Q;
                                    bus_held <= 1'b0;
                                end
                                default: state <= BIT_Q;
                            endcase
                        end
                    end
                end
                START_Q: begin
                    if (tick) begin
                        if (!started) begin
                            started       <= 1'b1;
                            quarter       <= 2'd0;
                            sda_drive_low <= 1'b0;
                        end else if (quarter == 2'd0) begin
                            quarter       <= 2'd1;
                            scl_drive_low <= 1'b0;
                        end else if (quarter == 2'd1) begin
                            if (scl_sync[1]) begin
                                quarter       <= 2'd2;
                                sda_drive_low <= 1'b1;
                            end
                        end else begin
                            quarter       <= 2'd3;
                            scl_drive_low <= 1'b1;
                            state         <= DONE;
                            done          <= 1'b1;
                            err           <= 1'b0;
                        end
                    end
                end
                BIT_Q: begin
                    if (tick) begin
                        if (!started || quarter == 2'd3) begin
                            started       <= 1'b1;
                            quarter       <= 2'd0;
                            bit_cnt       <= next_bit;
                            scl_drive_low <= 1'b1;
                            sda_drive_low <= next_bit_low;
                        end else if (quarter == 2'd0) begin
                            quarter       <= 2'd1;
                            scl_drive_low <= 1'b0;
                        end else if (quarter == 2'd1) begin
                            // held here while a slave stretches SCL low
                            if (scl_sync[1]) begin
                                quarter <= 2'd2;
                                if (bit_cnt < 4'd8) begin
                                    rx_shift <= {rx_shift[6:0], sda_sync[1]};
                                end else begin
                                    ack_tmp <= sda_sync[1];
                                end
                            end
                        end else begin
                            quarter       <= 2'd3;
                            scl_drive_low <= 1'b1;
                            if (bit_cnt == 4'd8) begin
                                state <= DONE;
                                done  <= 1'b1;
                                err   <= 1'b0;
                                if (cmd_l == CMD_READ) begin
                                    rx_byte <= rx_shift;
                                end else begin
                                    ack_out <= ack_tmp;
                                end
                            end
                        end
                    end
                end
                STOP_Q: begin
                    if (tick) begin
                        if (!started) begin
                            started       <= 1'b1;
                            quarter       <= 2'd0;
                            scl_drive_low <= 1'b1;
                            sda_drive_low <= 1'b1;
                        end else if (quarter == 2'd0) begin
                            quarter       <= 2'd1;
                            scl_drive_low <= 1'b0;
                        end else if (quarter == 2'd1) begin
                            if (scl_sync[1]) begin
                                quarter       <= 2'd2;
                                sda_drive_low <= 1'b0;
                            end
                        end else begin
                            quarter <= 2'd3;
                            state   <= DONE;
                            done    <= 1'b1;
                            err     <= 1'b0;
                        end
                    end
                end
                REJECT: begin
                    state <= DONE;
                    done  <= 1'b1;
                    err   <= 1'b1;
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Bench for i2c_bit_engine: drives phase_clk itself, models an open-drain bus
// with a byte-level slave, and checks commands against expected bus behaviour.
module tb_i2c_bit_engine;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_STOP  = 2'd3;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       phase_clk;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] tx_byte;
    logic       ack_in;
    logic [7:0] rx_byte;
    logic       ack_out;
    logic       done;
    logic       err;
    logic       busy;
    logic       scl_i;
    logic       sda_i;
    logic       scl_drive_low;
    logic       sda_drive_low;

    logic       slave_scl_low;
    logic       slave_sda_low;
    int         slave_mode;
    logic       slave_nack;
    logic [7:0] slave_data;
    int         slave_base;
    int         slave_falls_total = 0;

    logic       sda_hist [64];
    logic       drv_hist [64];
    int         rise_total  = 0;
    int         start_total = 0;
    int         stop_total  = 0;

    int         compared   = 0;
    int         mismatched = 0;

    int         toggles;
    logic       got_done;
    int         done_cycle;
    logic       err_at_done;
    logic       any_drive;
    logic       any_sda_drive;
    logic       rx_changed;
    logic       ready_c1;
    logic       scl_at_release;
    logic [7:0] rx_start;
    int         stretch_on_at  = 0;
    int         stretch_off_at = 0;

    i2c_bit_engine dut (
        .clock_in      (clock_in),
        .reset_n       (reset_n),
        .phase_clk     (phase_clk),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd           (cmd),
        .tx_byte       (tx_byte),
        .ack_in        (ack_in),
        .rx_byte       (rx_byte),
        .ack_out       (ack_out),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .scl_i         (scl_i),
        .sda_i         (sda_i),
        .scl_drive_low (scl_drive_low),
        .sda_drive_low (sda_drive_low)
    );

    always #5 clock_in = ~clock_in;

    assign scl_i = ~(scl_drive_low | slave_scl_low);
    assign sda_i = ~(sda_drive_low | slave_sda_low);

    // Slave counts SCL falls since the byte began and drives data/ACK while SCL is low
    always @(negedge scl_i) slave_falls_total = slave_falls_total + 1;

    always_comb begin
        int         f;
        logic [7:0] sh;
        f             = slave_falls_total - slave_base;
        sh            = slave_data >> (7 - f);
        slave_sda_low = 1'b0;
        if (slave_mode == 1) begin
            slave_sda_low = (f == 8) && !slave_nack;
        end else if (slave_mode == 2 && f >= 0 && f < 8) begin
            slave_sda_low = ~sh[0];
        end
    end

    always @(posedge scl_i) begin
        sda_hist[rise_total % 64] = sda_i;
        drv_hist[rise_total % 64] = sda_drive_low;
        rise_total = rise_total + 1;
    end

    always @(negedge sda_i) if (scl_i === 1'b1) start_total = start_total + 1;
    always @(posedge sda_i) if (scl_i === 1'b1) stop_total = stop_total + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitReady();
        for (int i = 0; i < 30 && cmd_ready !== 1'b1; i++) @(negedge clock_in);
        checkOutput("ready_wait", 32'(cmd_ready), 32'd1);
    endtask

    // Issue one command and toggle phase_clk every 8 cycles until done or the tick budget
    task automatic applyStimulus(input logic [1:0] c, input logic [7:0] data, input logic ack,
                                 input int max_toggles);
        int last_toggle;
        toggles        = 0;
        got_done       = 1'b0;
        done_cycle     = 0;
        err_at_done    = 1'b0;
        any_drive      = 1'b0;
        any_sda_drive  = 1'b0;
        rx_changed     = 1'b0;
        ready_c1       = 1'b1;
        scl_at_release = 1'b1;
        rx_start       = rx_byte;
        last_toggle    = 0;
        @(negedge clock_in);
        cmd       = c;
        tx_byte   = data;
        ack_in    = ack;
        cmd_valid = 1'b1;
        for (int cyc = 1; cyc <= 8 * max_toggles + 16; cyc++) begin
            @(negedge clock_in);
            if (cyc == 1) begin
                cmd_valid = 1'b0;
                ready_c1  = cmd_ready;
            end
            any_drive     = any_drive | scl_drive_low | sda_drive_low;
            any_sda_drive = any_sda_drive | sda_drive_low;
            if (done === 1'b1) begin
                got_done    = 1'b1;
                done_cycle  = cyc;
                err_at_done = err;
                break;
            end
            if (rx_byte !== rx_start) rx_changed = 1'b1;
            if (toggles > 0 && cyc == last_toggle + 5) begin
                if (toggles == stretch_on_at) slave_scl_low = 1'b1;
                if (toggles == stretch_off_at) begin
                    scl_at_release = scl_drive_low;
                    slave_scl_low  = 1'b0;
                end
            end
            if (toggles == max_toggles && cyc >= last_toggle + 5) break;
            if ((cyc % 8) == 3 && toggles < max_toggles) begin
                phase_clk   = ~phase_clk;
                toggles     = toggles + 1;
                last_toggle = cyc;
            end
        end
    endtask

    task automatic idleTicks(input int n);
        any_drive = 1'b0;
        for (int t = 0; t < n; t++) begin
            phase_clk = ~phase_clk;
            for (int i = 0; i < 8; i++) begin
                @(negedge clock_in);
                any_drive = any_drive | scl_drive_low | sda_drive_low;
            end
        end
    endtask

    task automatic getSamples(input int r0, output logic [8:0] sda9, output logic [8:0] drv9);
        sda9 = '0;
        drv9 = '0;
        for (int i = 0; i < 9; i++) begin
            sda9 = {sda9[7:0], sda_hist[(r0 + i) % 64]};
            drv9 = {drv9[7:0], drv_hist[(r0 + i) % 64]};
        end
    endtask

    task automatic doStart(input string tag);
        int s0;
        slave_mode = 0;
        waitReady();
        s0 = start_total;
        applyStimulus(CMD_START, 8'h00, 1'b0, 60);
        checkOutput({tag, ":done"}, 32'(got_done), 32'd1);
        checkOutput({tag, ":ticks"}, 32'(toggles), 32'd4);
        checkOutput({tag, ":err"}, 32'(err_at_done), 32'd0);
        checkOutput({tag, ":start_cond"}, 32'(start_total - s0), 32'd1);
    endtask

    task automatic doStop(input string tag);
        int s0;
        slave_mode = 0;
        waitReady();
        s0 = stop_total;
        applyStimulus(CMD_STOP, 8'h00, 1'b0, 60);
        checkOutput({tag, ":done"}, 32'(got_done), 32'd1);
        checkOutput({tag, ":ticks"}, 32'(toggles), 32'd4);
        checkOutput({tag, ":err"}, 32'(err_at_done), 32'd0);
        checkOutput({tag, ":stop_cond"}, 32'(stop_total - s0), 32'd1);
    endtask

    task automatic doWrite(input string tag, input logic [7:0] data, input logic nack, input int stretch);
        int         r0;
        logic [8:0] sda9;
        logic [8:0] drv9;
        waitReady();
        slave_base = slave_falls_total;
        slave_nack = nack;
        slave_mode = 1;
        r0         = rise_total;
        if (stretch > 0) begin
            stretch_on_at  = 9;
            stretch_off_at = 10 + stretch;
        end
        applyStimulus(CMD_WRITE, data, 1'b0, 60);
        stretch_on_at  = 0;
        stretch_off_at = 0;
        slave_mode     = 0;
        getSamples(r0, sda9, drv9);
        checkOutput({tag, ":done"}, 32'(got_done), 32'd1);
        checkOutput({tag, ":ticks"}, 32'(toggles), 32'(36 + stretch));
        checkOutput({tag, ":err"}, 32'(err_at_done), 32'd0);
        checkOutput({tag, ":ack_out"}, 32'(ack_out), 32'(nack));
        checkOutput({tag, ":scl_rises"}, 32'(rise_total - r0), 32'd9);
        checkOutput({tag, ":sda_bits"}, 32'(sda9), 32'({data, nack}));
        checkOutput({tag, ":bit9_released"}, 32'(drv9[0]), 32'd0);
        if (stretch > 0) checkOutput({tag, ":held_in_q1"}, 32'(scl_at_release), 32'd0);
    endtask

    task automatic doRead(input string tag, input logic [7:0] data, input logic ack);
        int         r0;
        logic [8:0] sda9;
        logic [8:0] drv9;
        waitReady();
        slave_base = slave_falls_total;
        slave_data = data;
        slave_mode = 2;
        r0         = rise_total;
        applyStimulus(CMD_READ, 8'($urandom), ack, 60);
        slave_mode = 0;
        getSamples(r0, sda9, drv9);
        checkOutput({tag, ":done"}, 32'(got_done), 32'd1);
        checkOutput({tag, ":ticks"}, 32'(toggles), 32'd36);
        checkOutput({tag, ":err"}, 32'(err_at_done), 32'd0);
        checkOutput({tag, ":rx_byte"}, 32'(rx_byte), 32'(data));
        checkOutput({tag, ":rx_held"}, 32'(rx_changed), 32'd0);
        checkOutput({tag, ":sda_bits"}, 32'(sda9), 32'({data, ack}));
        checkOutput({tag, ":master_drive"}, 32'(drv9), 32'({8'h00, ~ack}));
        if (ack) checkOutput({tag, ":sda_released"}, 32'(any_sda_drive), 32'd0);
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] d;
        logic       n;
        logic       a;
        reset_n       = 1'b0;
        phase_clk     = 1'b0;
        cmd_valid     = 1'b0;
        cmd           = CMD_START;
        tx_byte       = 8'h00;
        ack_in        = 1'b1;
        slave_scl_low = 1'b0;
        slave_mode    = 0;
        slave_nack    = 1'b0;
        slave_data    = 8'h00;
        slave_base    = 0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clock_in);
            phase_clk = ~phase_clk;
        end
        @(negedge clock_in);
        checkOutput("reset:scl_drive_low", 32'(scl_drive_low), 32'd0);
        checkOutput("reset:sda_drive_low", 32'(sda_drive_low), 32'd0);
        checkOutput("reset:cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset:busy", 32'(busy), 32'd0);
        checkOutput("reset:done", 32'(done), 32'd0);
        checkOutput("reset:err", 32'(err), 32'd0);
        checkOutput("reset:ack_out", 32'(ack_out), 32'd1);
        checkOutput("reset:rx_byte", 32'(rx_byte), 32'h00);
        reset_n = 1'b1;
        repeat (6) @(negedge clock_in);

        $display("[TB] rejection from idle bus");
        waitReady();
        applyStimulus(CMD_WRITE, 8'h55, 1'b0, 60);
        checkOutput("reject:ready_fall", 32'(ready_c1), 32'd0);
        checkOutput("reject:done", 32'(got_done), 32'd1);
        checkOutput("reject:latency", 32'(done_cycle), 32'd2);
        checkOutput("reject:err", 32'(err_at_done), 32'd1);
        checkOutput("reject:no_tick", 32'(toggles), 32'd0);
        idleTicks(20);
        checkOutput("reject:no_pins", 32'(any_drive), 32'd0);

        $display("[TB] directed START / WRITE A5 / READ 3C / STOP");
        doStart("start1");
        doWrite("write_a5", 8'hA5, 1'b0, 0);
        doRead("read_3c", 8'h3C, 1'b1);
        doStop("stop1");

        $display("[TB] randomized transfers with repeated starts");
        for (int k = 0; k < 3; k++) begin
            w = 8'($urandom);
            n = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            a = 1'($urandom_range(0, 1));
            doStart("rstart");
            doWrite("rwrite", w, n, 0);
            doRead("rread", d, a);
        end
        doStop("rstop");

        $display("[TB] clock stretching in bit 3");
        doStart("start_st");
        doWrite("write_stretch", 8'($urandom), 1'b0, 10);
        doStop("stop_st");

        $display("[TB] reset in the middle of a WRITE");
        doStart("start_rst");
        waitReady();
        slave_base = slave_falls_total;
        slave_nack = 1'b0;
        slave_mode = 1;
        applyStimulus(CMD_WRITE, 8'($urandom), 1'b0, 17);
        checkOutput("midrst:not_done", 32'(got_done), 32'd0);
        reset_n = 1'b0;
        @(negedge clock_in);
        checkOutput("midrst:scl_drive_low", 32'(scl_drive_low), 32'd0);
        checkOutput("midrst:sda_drive_low", 32'(sda_drive_low), 32'd0);
        checkOutput("midrst:cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("midrst:rx_byte", 32'(rx_byte), 32'h00);
        reset_n    = 1'b1;
        slave_mode = 0;
        repeat (6) @(negedge clock_in);
        waitReady();
        applyStimulus(CMD_WRITE, 8'h0F, 1'b0, 60);
        checkOutput("midrst:reject_done", 32'(got_done), 32'd1);
        checkOutput("midrst:reject_latency", 32'(done_cycle), 32'd2);
        checkOutput("midrst:reject_err", 32'(err_at_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/i2c_bit_engine.md
# i2c_bit_engine

Byte-level I2C master bit engine that consumes the toggling output of the slow clock divider as its quarter-bit timebase. Each command (START, WRITE byte, READ byte, STOP) is executed as a sequence of quarter-period phases on the open-drain SCL/SDA pins. Clock stretching is supported. The block sits between the slow clock divider and the register/controller layer that issues transfers.

## Interface
- No parameters. The bit rate is set entirely by `phase_clk`.
- `clock_in` in 1: system clock. All logic is on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `phase_clk` in 1: slow clock from the divider; asynchronous to this block's logic.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high when a command can be accepted (state IDLE).
- `cmd` in 2: command code.
  - 0 = START.
  - 1 = WRITE.
  - 2 = READ.
  - 3 = STOP.
- `tx_byte` in 8: byte for WRITE, sent MSB first.
- `ack_in` in 1: level the master drives in the 9th bit of a READ (0 = ACK).
- `rx_byte` out 8: byte received by the last READ.
- `ack_out` out 1: slave ACK sampled in the 9th bit of the last WRITE (0 = ACK).
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: valid with `done`; 1 = command rejected.
- `busy` out 1: equals ~`cmd_ready`.
- `scl_i`, `sda_i` in 1 each: pad input levels, asynchronous.
- `scl_drive_low`, `sda_drive_low` out 1 each: 1 = pull the line low, 0 = release it.

## Operation
- **Input sync:** `phase_clk`, `scl_i` and `sda_i` each pass through a 2-flop synchronizer.
- **Tick:** a one-cycle pulse on every edge (rising or falling) of synchronized `phase_clk`. Each tick advances one quarter (q0..q3).
- **Accept:** a command is accepted when `cmd_valid && cmd_ready`. On accept, `cmd`, `tx_byte` and `ack_in` are latched.
- **State machine:** IDLE → START_Q / BIT_Q / STOP_Q → DONE → IDLE.
- **bus_held flag:** set by START, cleared by STOP.
- **Rejection:**
  - WRITE, READ or STOP while bus_held=0 is rejected.
  - START is always legal; START while bus_held=1 is a repeated start.
  - A rejected command goes straight to DONE with `err`=1 and causes no pin activity.
- **Quarter actions** (each applied on the tick that enters that quarter):
  - **START:**
    - q0: release SDA, SCL unchanged.
    - q1: release SCL.
    - q2: drive SDA low.
    - q3: drive SCL low.
  - **BIT** (9 bits per byte):
    - q0: SCL low; drive SDA from the bit value.
    - q1: release SCL.
    - q2: sample `sda_i`.
    - q3: SCL low.
  - **WRITE:**
    - Bits 1-8 drive `tx_byte[7]`..`tx_byte[0]` (SDA driven low for a 0, released for a 1).
    - Bit 9 releases SDA; the q2 sample goes to `ack_out`.
  - **READ:**
    - Bits 1-8 release SDA; q2 samples shift into `rx_byte` MSB first.
    - Bit 9 drives SDA low if `ack_in`=0, otherwise releases it.
    - `rx_byte` updates only at DONE; it holds the previous value during the transfer.
  - **STOP:**
    - q0: SCL low, SDA low.
    - q1: release SCL.
    - q2: release SDA.
    - q3: no pin change.
- **Clock stretching:** the transition from q1 to q2 (START, BIT and STOP) happens only on a tick where synchronized `scl_i`=1. Otherwise the engine stays in q1 and waits for a later tick.
- **Reset:** all outputs and state return to reset values on the next clock edge, including mid-transfer. The bus may be left mid-byte; recovery is the controller's job.
- No arbitration-loss detection. Single master only.

## Timing
- **Reset values:**
  - `scl_drive_low`=0, `sda_drive_low`=0.
  - `cmd_ready`=1, `busy`=0.
  - `done`=0, `err`=0.
  - `rx_byte`=0x00, `ack_out`=1.
  - bus_held=0.
- **Tick delay:** a tick occurs 3 `clock_in` cycles after a `phase_clk` transition.
- **Accept timing:**
  - `cmd_ready` falls on the cycle after acceptance.
  - A tick in the acceptance cycle is ignored; q0 starts on the next tick.
- **Duration without stretching:**
  - START = 4 ticks.
  - STOP = 4 ticks.
  - WRITE or READ = 36 ticks.
- **Completion:**
  - `done` pulses in the cycle after the final q3 tick.
  - `cmd_ready` returns to 1 in the cycle after `done`.
  - `rx_byte`, `ack_out` and `err` are valid from the `done` cycle onward.
- **Rejected command:** `done`/`err` pulse 2 cycles after accept, with no tick needed.
- Pin outputs are registered and change only in the cycle after a tick (or after reset).

## Test plan
- **Reset:** hold `reset_n`=0 for 5 cycles while `phase_clk` toggles → both drive_low=0, `cmd_ready`=1, `ack_out`=1, `rx_byte`=0x00, no `done`.
- **START + WRITE:** START, then WRITE 0xA5 with a slave model ACKing → SDA levels at the q2 samples read 1,0,1,0,0,1,0,1; 9th-bit SDA released; `ack_out`=0; `done` after 4 and 36 ticks; `err`=0.
- **READ:** READ with `ack_in`=1 and the slave returning 0x3C → `rx_byte`=0x3C at `done`; SDA released through all 9 bits; STOP then yields a SDA rising edge while SCL is high.
- **Rejection:** WRITE issued from reset (bus idle) → `done`&`err`=1 two cycles after accept; no drive_low activity for 20 ticks.
- **Clock stretching:** slave holds `scl_i` low for 10 ticks during bit 3 of a WRITE → the engine stays in q1; the sample is taken on the first tick after `scl_i` goes high; total WRITE = 46 ticks.
- **Reset mid-operation:** assert `reset_n`=0 at tick 17 of a WRITE → both drive_low=0 and `cmd_ready`=1 the next cycle; a following WRITE is rejected with `err`=1.
